// File: rtl/load_store_unit_if.sv
// Request/response bus between the execute stage and the load/store unit.
interface load_store_unit_if;
    logic        req;
    logic [5:0]  op;
    logic [31:0] adrs;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;

    modport master (
        output req, op, adrs, wdata,
        input  busy, done, fault, rdata
    );

    modport slave (
        input  req, op, adrs, wdata,
        output busy, done, fault, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer driving a word-granular memory port;
// sub-word stores are done as read-modify-write.
`ifndef N_RAM
`define N_RAM 1024
`endif

module load_store_unit #(
    parameter int N_RAM_WORDS = `N_RAM
) (
    input  logic                     clk_cpu,
    input  logic                     reset,
    load_store_unit_if.slave         cpu,
    output logic [31:0]              mem_adrs,
    output logic [31:0]              mem_data,
    output logic                     mem_we,
    input  logic [31:0]              mem_q
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [31:0] RAM_LIMIT = N_RAM_WORDS;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [5:0]  op_r;
    logic [31:0] adrs_r;
    logic [31:0] wdata_r;
    logic [31:0] merge_r;
    logic [31:0] rdata_r;
    logic        fault_r;

    logic        req_valid;
    logic        req_fault;
    logic        op_r_is_load;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Faults are judged on the raw request so a rejected access never reaches memory.
    always_comb begin
        req_valid = 1'b0;
        req_fault = 1'b0;
        case (cpu.op)
            OP_LB, OP_LBU, OP_SB: req_valid = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin
                req_valid = 1'b1;
                req_fault = cpu.adrs[0];
            end
            OP_LW, OP_SW: begin
                req_valid = 1'b1;
                req_fault = (cpu.adrs[1:0] != 2'b00);
            end
            default: req_valid = 1'b0;
        endcase
        if ({2'b00, cpu.adrs[31:2]} >= RAM_LIMIT)
            req_fault = 1'b1;
    end

    always_comb begin
        op_r_is_load = (op_r == OP_LB) || (op_r == OP_LH) || (op_r == OP_LW) ||
                       (op_r == OP_LBU) || (op_r == OP_LHU);
        byte_sel = mem_q[{adrs_r[1:0], 3'b000} +: 8];
        half_sel = mem_q[{adrs_r[1], 4'b0000} +: 16];
        case (op_r)
            OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {24'h000000, byte_sel};
            OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {16'h0000, half_sel};
            default: load_val = mem_q;
        endcase
    end

    always_comb begin
        merged = merge_r;
        if (op_r == OP_SB)
            merged[{adrs_r[1:0], 3'b000} +: 8] = wdata_r[7:0];
        else if (op_r == OP_SH)
            merged[{adrs_r[1], 4'b0000} +: 16] = wdata_r[15:0];
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op_r    <= 6'd0;
            adrs_r  <= 32'd0;
            wdata_r <= 32'd0;
            merge_r <= 32'd0;
            rdata_r <= 32'd0;
            fault_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu.req && req_valid) begin
                        op_r    <= cpu.op;
                        adrs_r  <= cpu.adrs;
                        wdata_r <= cpu.wdata;
                        fault_r <= req_fault;
                        if (req_fault)
                            state <= DONE;
                        else if (cpu.op == OP_SW)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    if (op_r_is_load) begin
                        rdata_r <= load_val;
                        state   <= DONE;
                    end else begin
                        merge_r <= mem_q;
                        state   <= WRITE;
                    end
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Every strobe is decoded straight from the state flop so async reset kills it at once.
    assign mem_we    = (state == WRITE);
    assign mem_adrs  = {adrs_r[31:2], 2'b00};
    assign mem_data  = (state != WRITE) ? 32'd0 : ((op_r == OP_SW) ? wdata_r : merged);
    assign cpu.busy  = (state != IDLE);
    assign cpu.done  = (state == DONE);
    assign cpu.fault = (state == DONE) && fault_r;
    assign cpu.rdata = rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed cases plus random requests against a word-array reference model.
module tb_load_store_unit;

    localparam int N_WORDS = 16;
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [31:0] mem_adrs;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_q;

    logic [31:0] dut_ram [N_WORDS];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    logic [31:0] ref_mem [N_WORDS];
    logic [31:0] ref_rdata;
    int          n_vectors = 0;
    int          n_miscompares = 0;

    load_store_unit_if lsu_bus ();

    load_store_unit #(.N_RAM_WORDS(N_WORDS)) dut (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .cpu      (lsu_bus.slave),
        .mem_adrs (mem_adrs),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .mem_q    (mem_q)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Stand-in for memory_controller: combinational read, whole-word write at the clock edge.
    assign mem_q = dut_ram[mem_adrs[5:2]];

    always @(posedge clk_cpu) begin
        if (pre_we)
            dut_ram[pre_idx] <= pre_val;
        else if (mem_we)
            dut_ram[mem_adrs[5:2]] <= mem_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected)
        else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit is_load(input logic [5:0] o);
        return (o == LB) || (o == LH) || (o == LW) || (o == LBU) || (o == LHU);
    endfunction

    function automatic bit model_fault(input logic [5:0] o, input logic [31:0] a);
        bit half_op = (o == LH) || (o == LHU) || (o == SH);
        bit word_op = (o == LW) || (o == SW);
        return (half_op && (a % 2 != 0)) || (word_op && (a % 4 != 0)) || ((a / 4) >= N_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] o, input logic [31:0] a);
        logic [31:0] w     = ref_mem[a / 4];
        logic [31:0] bytev = (w >> (8 * (a % 4))) & 32'hFF;
        logic [31:0] halfv = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (o)
            LB:      return (bytev >= 32'd128) ? bytev - 32'd256 : bytev;
            LBU:     return bytev;
            LH:      return (halfv >= 32'd32768) ? halfv - 32'd65536 : halfv;
            LHU:     return halfv;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] old = ref_mem[a / 4];
        int          sh_b = 8 * (a % 4);
        int          sh_h = 16 * ((a % 4) / 2);
        case (o)
            SB:      return (old & ~(32'hFF << sh_b)) | ((w & 32'hFF) << sh_b);
            SH:      return (old & ~(32'hFFFF << sh_h)) | ((w & 32'hFFFF) << sh_h);
            default: return w;
        endcase
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk_cpu);
        pre_we  = 1'b1;
        pre_idx = 4'(idx);
        pre_val = val;
        @(negedge clk_cpu);
        pre_we  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // One request end to end; optional junk requests are held high while busy to prove they are dropped.
    task automatic applyStimulus(input logic [5:0] o, input logic [31:0] a, input logic [31:0] w, input bit junk);
        bit          f = model_fault(o, a);
        int          lat;
        int          wc;
        logic [31:0] exp_word = 32'd0;
        logic [31:0] exp_load = 32'd0;
        if (f) begin
            lat = 1; wc = 0;
        end else if (is_load(o)) begin
            lat = 2; wc = 0;
            exp_load = model_load(o, a);
        end else if (o == SW) begin
            lat = 2; wc = 1;
            exp_word = model_store(o, a, w);
        end else begin
            lat = 3; wc = 2;
            exp_word = model_store(o, a, w);
        end
        @(negedge clk_cpu);
        lsu_bus.req   = 1'b1;
        lsu_bus.op    = o;
        lsu_bus.adrs  = a;
        lsu_bus.wdata = w;
        @(posedge clk_cpu);
        #1;
        if (junk) begin
            lsu_bus.op    = SW;
            lsu_bus.adrs  = 32'($urandom_range(0, 15)) << 2;
            lsu_bus.wdata = $urandom;
        end else begin
            lsu_bus.req = 1'b0;
        end
        for (int cyc = 1; cyc <= lat; cyc++) begin
            if (cyc == lat) begin
                if (!f && is_load(o))
                    ref_rdata = exp_load;
                if (!f && wc != 0)
                    ref_mem[a / 4] = exp_word;
            end
            checkOutput($sformatf("busy op=%h a=%h c%0d", o, a, cyc), 32'(lsu_bus.busy), 32'd1);
            checkOutput($sformatf("done op=%h a=%h c%0d", o, a, cyc), 32'(lsu_bus.done), 32'(cyc == lat));
            checkOutput($sformatf("mem_we op=%h a=%h c%0d", o, a, cyc), 32'(mem_we), 32'(cyc == wc));
            checkOutput($sformatf("mem_adrs op=%h a=%h c%0d", o, a, cyc), mem_adrs, {a[31:2], 2'b00});
            checkOutput($sformatf("mem_data op=%h a=%h c%0d", o, a, cyc), mem_data, (cyc == wc) ? exp_word : 32'd0);
            if (cyc == lat) begin
                checkOutput($sformatf("fault op=%h a=%h", o, a), 32'(lsu_bus.fault), 32'(f));
                checkOutput($sformatf("rdata op=%h a=%h", o, a), lsu_bus.rdata, ref_rdata);
            end else begin
                @(posedge clk_cpu);
                #1;
            end
        end
        @(posedge clk_cpu);
        #1;
        lsu_bus.req = 1'b0;
        checkOutput($sformatf("idle busy op=%h", o), 32'(lsu_bus.busy), 32'd0);
        checkOutput($sformatf("idle done op=%h", o), 32'(lsu_bus.done), 32'd0);
    endtask

    task automatic applyIgnored(input logic [5:0] o);
        @(negedge clk_cpu);
        lsu_bus.req  = 1'b1;
        lsu_bus.op   = o;
        lsu_bus.adrs = 32'h0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(posedge clk_cpu);
            #1;
            checkOutput($sformatf("ignored busy op=%h", o), 32'(lsu_bus.busy), 32'd0);
            checkOutput($sformatf("ignored done op=%h", o), 32'(lsu_bus.done), 32'd0);
        end
        lsu_bus.req = 1'b0;
    endtask

    initial begin
        logic [5:0]  ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        logic [31:0] a;
        int          r;

        reset         = 1'b1;
        pre_we        = 1'b0;
        pre_idx       = 4'd0;
        pre_val       = 32'd0;
        lsu_bus.req   = 1'b0;
        lsu_bus.op    = 6'd0;
        lsu_bus.adrs  = 32'd0;
        lsu_bus.wdata = 32'd0;
        ref_rdata     = 32'd0;
        for (int i = 0; i < N_WORDS; i++)
            preload(i, 32'd0);

        #1;
        checkOutput("reset busy", 32'(lsu_bus.busy), 32'd0);
        checkOutput("reset done", 32'(lsu_bus.done), 32'd0);
        checkOutput("reset fault", 32'(lsu_bus.fault), 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_data", mem_data, 32'd0);
        checkOutput("reset rdata", lsu_bus.rdata, 32'd0);
        checkOutput("reset mem_adrs", mem_adrs, 32'd0);
        @(negedge clk_cpu);
        reset = 1'b0;

        preload(2, 32'h8899AABB);
        applyStimulus(LW, 32'h08, 32'h0, 1'b0);

        preload(2, 32'h80112233);
        applyStimulus(LB, 32'h0B, 32'h0, 1'b0);
        applyStimulus(LBU, 32'h0B, 32'h0, 1'b0);
        applyStimulus(LB, 32'h08, 32'h0, 1'b0);

        preload(1, 32'h11223344);
        applyStimulus(SB, 32'h05, 32'hDEADBEA5, 1'b0);
        applyStimulus(LW, 32'h04, 32'h0, 1'b0);

        preload(3, 32'h0);
        applyStimulus(SH, 32'h0E, 32'h0000BEEF, 1'b0);
        applyStimulus(LW, 32'h0C, 32'h0, 1'b0);
        applyStimulus(LHU, 32'h0E, 32'h0, 1'b0);
        applyStimulus(LH, 32'h0E, 32'h0, 1'b0);

        applyStimulus(LW, 32'h06, 32'h0, 1'b0);
        applyStimulus(SW, 32'(N_WORDS * 4), 32'h12345678, 1'b0);
        applyStimulus(SH, 32'h03, 32'hCAFE, 1'b0);

        applyIgnored(6'h00);
        applyIgnored(6'h2A);

        // Reset landing in the WRITE cycle of a byte store must leave the RAM word untouched.
        preload(1, 32'h11223344);
        @(negedge clk_cpu);
        lsu_bus.req   = 1'b1;
        lsu_bus.op    = SB;
        lsu_bus.adrs  = 32'h05;
        lsu_bus.wdata = 32'hDEADBEA5;
        @(posedge clk_cpu);
        #1;
        lsu_bus.req = 1'b0;
        checkOutput("rst-seq read mem_we", 32'(mem_we), 32'd0);
        @(posedge clk_cpu);
        #1;
        checkOutput("rst-seq write mem_we", 32'(mem_we), 32'd1);
        checkOutput("rst-seq write mem_data", mem_data, 32'h1122A544);
        #2;
        reset = 1'b1;
        ref_rdata = 32'd0;
        #1;
        checkOutput("rst-seq mem_we drop", 32'(mem_we), 32'd0);
        checkOutput("rst-seq busy drop", 32'(lsu_bus.busy), 32'd0);
        checkOutput("rst-seq mem_data drop", mem_data, 32'd0);
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(posedge clk_cpu);
            #1;
            checkOutput("rst-seq no done", 32'(lsu_bus.done), 32'd0);
            checkOutput("rst-seq rdata", lsu_bus.rdata, ref_rdata);
        end
        applyStimulus(LW, 32'h04, 32'h0, 1'b0);
        applyStimulus(LW, 32'h00, 32'h0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 63));
            if (r < 5)
                a = a & ~32'h3;
            else if (r == 9)
                a = $urandom;
            applyStimulus(ops[$urandom_range(0, 7)], a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
